// File: rtl/cpu_core_seq.sv
// rtl/cpu_core_seq.sv - parametrised stored-program core with fetch/execute sequencing
// Host loads program and registers while idle, pulses run, then observes state.
module cpu_core_seq #(
  parameter  int DATA_W     = 8,
  parameter  int NREG       = 4,
  parameter  int PROG_DEPTH = 16,
  localparam int RW         = $clog2(NREG),
  localparam int PW         = $clog2(PROG_DEPTH),
  localparam int INSTR_W    = 4 + 2 * RW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               prog_we_i,
  input  logic [PW-1:0]      prog_addr_i,
  input  logic [INSTR_W-1:0] prog_data_i,
  input  logic               reg_we_i,
  input  logic [RW-1:0]      reg_addr_i,
  input  logic [DATA_W-1:0]  reg_data_i,
  input  logic               run_i,
  output logic               busy_o,
  output logic               halted_o,
  output logic [PW-1:0]      pc_o,
  input  logic [RW-1:0]      dbg_addr_i,
  output logic [DATA_W-1:0]  dbg_data_o,
  output logic [3:0]         flags_o,
  output logic               retired_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [3:0]          flags_q, flags_d;
  logic                busy_q, busy_d, halted_q, halted_d, retired_q, retired_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [INSTR_W-1:0]  prog_q [PROG_DEPTH];
  logic [INSTR_W-1:0]  prog_d [PROG_DEPTH];

  logic [3:0]          op;
  logic [RW-1:0]       dst, src;
  logic [DATA_W-1:0]   a, b, y, res;
  logic [DATA_W:0]     sum, diff;
  logic                c, v, wr, upd, taken;

  assign op  = ir_q[INSTR_W-1 -: 4];
  assign dst = ir_q[2*RW-1 -: RW];
  assign src = ir_q[RW-1:0];
  assign a   = regs_q[dst];
  assign b   = regs_q[src];
  // INC/DEC reuse the ADD/SUB paths with a constant one operand
  assign y    = (op == 4'hA || op == 4'hB) ? DATA_W'(1) : b;
  assign sum  = {1'b0, a} + {1'b0, y};
  assign diff = {1'b0, a} - {1'b0, y};

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    wr  = 1'b0;
    upd = 1'b0;
    unique case (op)
      4'h1, 4'hA: begin
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a[DATA_W-1] == y[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        wr  = 1'b1;
        upd = 1'b1;
      end
      4'h2, 4'hB, 4'hC: begin
        res = diff[DATA_W-1:0];
        c   = diff[DATA_W];
        v   = (a[DATA_W-1] != y[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        wr  = (op != 4'hC);
        upd = 1'b1;
      end
      4'h3: begin res = a & b; wr = 1'b1; upd = 1'b1; end
      4'h4: begin res = a | b; wr = 1'b1; upd = 1'b1; end
      4'h5: begin res = a ^ b; wr = 1'b1; upd = 1'b1; end
      4'h6: begin res = ~a;    wr = 1'b1; upd = 1'b1; end
      4'h7: begin res = a << 1; c = a[DATA_W-1]; wr = 1'b1; upd = 1'b1; end
      4'h8: begin res = a >> 1; c = a[0];        wr = 1'b1; upd = 1'b1; end
      4'h9: begin res = b; wr = 1'b1; upd = 1'b1; end
      default: ;
    endcase
  end

  assign taken = (op == 4'hD && flags_q[1]) || (op == 4'hE && !flags_q[1]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    busy_d    = busy_q;
    halted_d  = halted_q;
    retired_d = 1'b0;
    regs_d    = regs_q;
    prog_d    = prog_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (prog_we_i) prog_d[prog_addr_i] = prog_data_i;
        if (reg_we_i)  regs_d[reg_addr_i]  = reg_data_i;
        if (run_i) begin
          pc_d     = '0;
          flags_d  = '0;
          halted_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d      = prog_q[pc_q];
        retired_d = 1'b1;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        if (wr)  regs_d[dst] = res;
        if (upd) flags_d = {res[DATA_W-1], v, (res == '0), c};
        if (op == 4'hF || (!taken && pc_q == PW'(PROG_DEPTH - 1))) begin
          busy_d   = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          pc_d    = taken ? PW'(b) : pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 1'b0;
      regs_q    <= '{default: '0};
      prog_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
      prog_q    <= prog_d;
    end
  end

  assign busy_o     = busy_q;
  assign halted_o   = halted_q;
  assign retired_o  = retired_q;
  assign pc_o       = pc_q;
  assign flags_o    = flags_q;
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: tb/tb_cpu_core_seq.sv
// tb/tb_cpu_core_seq.sv - self-checking bench for cpu_core_seq
module tb_cpu_core_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_we, reg_we, run;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [1:0] reg_addr, dbg_addr;
  logic [7:0] reg_data, dbg_data;
  logic       busy, halted, retired;
  logic [3:0] pc, flags;

  cpu_core_seq #(.DATA_W(8), .NREG(4), .PROG_DEPTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
    .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .run_i(run), .busy_o(busy), .halted_o(halted), .pc_o(pc),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data),
    .flags_o(flags), .retired_o(retired)
  );

  always #5 clk = ~clk;

  int ret_total = 0;
  always @(negedge clk) if (retired) ret_total++;

  typedef struct {
    string      name;
    logic [7:0] r0, r1, instr, er0;
    logic [3:0] ef;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] r0;
    logic [3:0] fl;
    logic [3:0] pc;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic host_reg(input logic [1:0] idx, input logic [7:0] d);
    @(posedge clk); #1;
    reg_we = 1'b1; reg_addr = idx; reg_data = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic host_prog(input logic [3:0] addr, input logic [7:0] d);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = addr; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    @(posedge clk); #1;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (halted) begin
        cyc = n;
        break;
      end
    end
    #2;
    chk("halt_reached", halted, 1'b1);
  endtask

  task automatic rd_reg(input logic [1:0] idx, output logic [7:0] val);
    dbg_addr = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t       vecs[$];
  exp_t       e;
  logic [7:0] rv;
  logic [5:0] ret_map, halt_map;
  int         cyc, snap, seen;

  initial begin
    rst_n = 1'b0; prog_we = 0; reg_we = 0; run = 0;
    prog_addr = 0; prog_data = 0; reg_addr = 0; reg_data = 0; dbg_addr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", flags, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i[1:0], rv);
      chk($sformatf("rst_r%0d", i), rv, 0);
    end

    // ADD r0,r1 then HALT: exact retire/halt cycle positions after run
    host_reg(0, 8'h05); host_reg(1, 8'h03);
    host_prog(0, 8'h11); host_prog(1, 8'hF0);
    start_run();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ret_map[c]  = retired;
      halt_map[c] = halted;
    end
    chk("t1_retire_map", ret_map, 6'b001010);
    chk("t1_halt_map", halt_map, 6'b110000);
    chk("t1_pc", pc, 1);
    chk("t1_flags", flags, 4'b0000);
    rd_reg(0, rv);
    chk("t1_r0", rv, 8'h08);

    // flags are {N,V,Z,C}; instr = {op, dst=r0, src=r1}
    vecs = '{
      '{"add_carry", 8'hFF, 8'h01, 8'h11, 8'h00, 4'b0011},
      '{"add_ovf",   8'h7F, 8'h01, 8'h11, 8'h80, 4'b1100},
      '{"sub_borrow",8'h03, 8'h05, 8'h21, 8'hFE, 4'b1001},
      '{"sub_ovf",   8'h80, 8'h01, 8'h21, 8'h7F, 4'b0100},
      '{"and",       8'hF0, 8'h3C, 8'h31, 8'h30, 4'b0000},
      '{"or_zero",   8'h00, 8'h00, 8'h41, 8'h00, 4'b0010},
      '{"xor_zero",  8'hAA, 8'hAA, 8'h51, 8'h00, 4'b0010},
      '{"not",       8'h0F, 8'h55, 8'h61, 8'hF0, 4'b1000},
      '{"shl",       8'h81, 8'h00, 8'h71, 8'h02, 4'b0001},
      '{"shr",       8'h81, 8'h00, 8'h81, 8'h40, 4'b0001},
      '{"mov",       8'h12, 8'h80, 8'h91, 8'h80, 4'b1000},
      '{"inc_ovf",   8'h7F, 8'h00, 8'hA1, 8'h80, 4'b1100},
      '{"inc_wrap",  8'hFF, 8'h00, 8'hA1, 8'h00, 4'b0011},
      '{"dec_ovf",   8'h80, 8'h00, 8'hB1, 8'h7F, 4'b0100},
      '{"dec_wrap",  8'h00, 8'h00, 8'hB1, 8'hFF, 4'b1001},
      '{"cmp_eq",    8'h05, 8'h05, 8'hC1, 8'h05, 4'b0010},
      '{"cmp_lt",    8'h03, 8'h05, 8'hC1, 8'h03, 4'b1001},
      '{"nop",       8'h5A, 8'h00, 8'h01, 8'h5A, 4'b0000}
    };
    foreach (vecs[i]) begin
      host_reg(0, vecs[i].r0); host_reg(1, vecs[i].r1);
      host_prog(0, vecs[i].instr); host_prog(1, 8'hF0);
      sb.push_back('{vecs[i].name, vecs[i].er0, vecs[i].ef, 4'd1});
      start_run();
      wait_halt(cyc);
      e = sb.pop_front();
      rd_reg(0, rv);
      chk({e.name, "_r0"}, rv, e.r0);
      chk({e.name, "_flags"}, flags, e.fl);
      chk({e.name, "_pc"}, pc, e.pc);
    end

    // DEC/JNZ loop
    host_reg(0, 8'h03); host_reg(2, 8'h00);
    host_prog(0, 8'hB0); host_prog(1, 8'hE2); host_prog(2, 8'hF0);
    snap = ret_total;
    start_run();
    wait_halt(cyc);
    chk("loop_retired", ret_total - snap, 7);
    chk("loop_pc", pc, 2);
    chk("loop_z", flags[1], 1'b1);
    rd_reg(0, rv);
    chk("loop_r0", rv, 0);

    // all-NOP program runs off the end of memory
    do_reset();
    host_reg(1, 8'h5A); host_reg(3, 8'hC3);
    snap = ret_total;
    start_run();
    wait_halt(cyc);
    chk("nop_halt_cycle", cyc, 33);
    chk("nop_retired", ret_total - snap, 16);
    chk("nop_pc", pc, 15);
    chk("nop_flags", flags, 0);
    rd_reg(1, rv); chk("nop_r1", rv, 8'h5A);
    rd_reg(3, rv); chk("nop_r3", rv, 8'hC3);

    // host writes and run are ignored while busy
    host_reg(0, 8'h11);
    snap = ret_total;
    start_run();
    @(posedge clk); #1;
    reg_we = 1; reg_addr = 0; reg_data = 8'hAA;
    prog_we = 1; prog_addr = 3; prog_data = 8'hF0;
    run = 1;
    @(posedge clk); #1;
    reg_we = 0; prog_we = 0; run = 0;
    wait_halt(cyc);
    chk("busy_wr_pc", pc, 15);
    chk("busy_wr_retired", ret_total - snap, 16);
    rd_reg(0, rv); chk("busy_wr_r0", rv, 8'h11);
    host_reg(0, 8'hAA);
    host_prog(3, 8'hF0);
    rd_reg(0, rv); chk("idle_wr_dbg", rv, 8'hAA);
    start_run();
    wait_halt(cyc);
    chk("idle_wr_prog_pc", pc, 3);

    // asynchronous reset in the middle of EXEC
    host_reg(0, 8'hFF); host_reg(1, 8'h01); host_prog(0, 8'h11);
    start_run();
    seen = 0;
    for (int n = 0; n < 20 && seen < 2; n++) begin
      @(negedge clk);
      if (retired) seen++;
    end
    chk("mid_exec_reached", seen, 2);
    chk("mid_flags_pre", flags, 4'b0011);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_halted", halted, 0);
    chk("mid_pc", pc, 0);
    chk("mid_flags", flags, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i[1:0], rv);
      chk($sformatf("mid_r%0d", i), rv, 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    snap = ret_total;
    start_run();
    wait_halt(cyc);
    chk("post_rst_pc", pc, 15);
    chk("post_rst_retired", ret_total - snap, 16);
    chk("post_rst_flags", flags, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
